// File: rtl/seven_seg_sched_pkg.sv
// Shared types and constants for the seven-segment display scheduler.
// Optional build macro: SEVEN_SEG_SCHED_PRIO_EN (source 0 preempts the rotation).
package seven_seg_sched_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHOW,
    BLANK
  } state_t;

  localparam int DEF_DWELL_CYCLES = 12_000_000;  // 1 s at 12 MHz
  localparam int DEF_BLANK_CYCLES = 1200;

  // Width of an index able to address n items; never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/seven_seg_sched_rr_pick.sv
// Combinational round-robin picker: first requester after 'last', wrapping modulo N.
// Shared with other schedulers; holds no state.
module rr_pick
  import seven_seg_sched_pkg::*;
#(
  parameter int N = 4,
  parameter int W = idx_w(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] last,
  output logic [W-1:0] winner,
  output logic         any
);

  logic [W-1:0] idx;

  // NOTE: every output of a combinational block gets a default first so no latch is inferred.
  always_comb begin
    winner = '0;
    any    = 1'b0;
    idx    = '0;
    // Walk from the farthest candidate inwards so the nearest requester is written last.
    for (int k = N; k >= 1; k--) begin
      idx = W'((int'(last) + k) % N);
      if (req[idx]) begin
        winner = idx;
        any    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/seven_seg_sched.sv
// Round-robin time-sharing of a two-digit display between N_SRC byte producers.
// Optional build macro: SEVEN_SEG_SCHED_PRIO_EN (req[0] rising edge preempts other sources).
module seven_seg_sched
  import seven_seg_sched_pkg::*;
#(
  parameter int N_SRC        = 4,
  parameter int DWELL_CYCLES = DEF_DWELL_CYCLES,
  parameter int BLANK_CYCLES = DEF_BLANK_CYCLES,
  localparam int SRC_W       = idx_w(N_SRC),
  localparam int CNT_W       = idx_w((DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N_SRC-1:0]   req,
  input  logic [8*N_SRC-1:0] data,
  input  logic               hold,
  output logic [N_SRC-1:0]   ack,
  output logic [7:0]         disp_byte,
  output logic [SRC_W-1:0]   disp_src,
  output logic               disp_valid
);

  state_t           state;
  logic [SRC_W-1:0] last;
  logic [CNT_W-1:0] cnt;
  logic [7:0]       src_byte [N_SRC];
  logic [SRC_W-1:0] rr_winner;
  logic [SRC_W-1:0] grant_src;
  logic             rr_any;
  logic             grant;
  logic             preempt;
  logic             others_req;
  logic             dwell_done;
  logic             blank_done;
  logic [N_SRC-1:0] cur_mask;

  for (genvar i = 0; i < N_SRC; i++) begin : g_byte
    assign src_byte[i] = data[8*i +: 8];
  end

  rr_pick #(
    .N (N_SRC),
    .W (SRC_W)
  ) u_rr_pick (
    .req    (req),
    .last   (last),
    .winner (rr_winner),
    .any    (rr_any)
  );

  // The same counter times both the dwell and the blank gap.
  assign dwell_done = (cnt == CNT_W'(DWELL_CYCLES - 1)) && !hold;
  assign blank_done = (cnt == CNT_W'(BLANK_CYCLES - 1));

  always_comb begin
    cur_mask           = '0;
    cur_mask[disp_src] = 1'b1;
  end

  assign others_req = |(req & ~cur_mask);

`ifdef SEVEN_SEG_SCHED_PRIO_EN
  logic req0_q;
  logic prio_pend;
  logic rise0;

  assign rise0   = req[0] && !req0_q;
  assign preempt = rise0 && (disp_src != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req0_q    <= 1'b0;
      prio_pend <= 1'b0;
    end else begin
      req0_q <= req[0];
      if (grant)
        prio_pend <= 1'b0;
      else if (rise0 && ((state == SHOW && disp_src != '0) || state == BLANK))
        prio_pend <= 1'b1;
    end
  end

  always_comb begin
    grant     = 1'b0;
    grant_src = rr_winner;
    if (state == IDLE) begin
      grant = rr_any;
    end else if (state == BLANK && blank_done) begin
      grant = rr_any;
      if ((prio_pend || rise0) && req[0]) grant_src = '0;
    end
  end
`else
  assign preempt = 1'b0;

  always_comb begin
    grant     = 1'b0;
    grant_src = rr_winner;
    if (state == IDLE || (state == BLANK && blank_done)) grant = rr_any;
  end
`endif

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      last       <= SRC_W'(N_SRC - 1);
      cnt        <= '0;
      disp_byte  <= '0;
      disp_src   <= '0;
      disp_valid <= 1'b0;
      ack        <= '0;
    end else begin
      ack <= '0;
      if (grant) begin
        state          <= SHOW;
        disp_src       <= grant_src;
        last           <= grant_src;
        disp_byte      <= src_byte[grant_src];
        disp_valid     <= 1'b1;
        cnt            <= '0;
        ack[grant_src] <= 1'b1;
      end else begin
        unique case (state)
          SHOW: begin
            disp_byte <= src_byte[disp_src];
            if (dwell_done && !others_req && req[disp_src]) begin
              cnt <= '0;
            end else if (dwell_done && !others_req) begin
              state      <= IDLE;
              disp_valid <= 1'b0;
            end else if (dwell_done || !req[disp_src] || preempt) begin
              state      <= BLANK;
              disp_valid <= 1'b0;
              disp_byte  <= '0;
              cnt        <= '0;
            end else if (!hold) begin
              cnt <= cnt + 1'b1;
            end
          end
          BLANK: begin
            if (blank_done) state <= IDLE;
            else            cnt   <= cnt + 1'b1;
          end
          default: ;  // IDLE only leaves through a grant
        endcase
      end
    end
  end

  ack_matches_src: assert property (@(posedge clk) disable iff (!rst_n)
    (ack == '0) || (ack == cur_mask));

  src_in_range: assert property (@(posedge clk) disable iff (!rst_n)
    int'(disp_src) < N_SRC);

endmodule

// File: tb/tb_seven_seg_sched.sv
// Directed self-checking bench for seven_seg_sched (N_SRC=4, DWELL=8, BLANK=2).
// Expected preemption latency follows SEVEN_SEG_SCHED_PRIO_EN when the bench is built with it.
module tb_seven_seg_sched;

  localparam int N = 4;

  logic           clk   = 1'b0;
  logic           rst_n = 1'b0;
  logic           hold  = 1'b0;
  logic [N-1:0]   req   = '0;
  logic [8*N-1:0] data  = '0;
  logic [N-1:0]   ack;
  logic [7:0]     disp_byte;
  logic [1:0]     disp_src;
  logic           disp_valid;

  int n_checks = 0;
  int n_errors = 0;
  int grants[$];
  int gsrc[$];
  int hi_runs[$];
  int lo_runs[$];

  always #5 clk = ~clk;

  seven_seg_sched #(
    .N_SRC        (N),
    .DWELL_CYCLES (8),
    .BLANK_CYCLES (2)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (req),
    .data       (data),
    .hold       (hold),
    .ack        (ack),
    .disp_byte  (disp_byte),
    .disp_src   (disp_src),
    .disp_valid (disp_valid)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req   = '0;
    hold  = 1'b0;
    step(2);
    rst_n = 1'b1;
  endtask

  function automatic int ack_idx(input logic [N-1:0] v);
    for (int i = 0; i < N; i++)
      if (v[i]) return i;
    return -1;
  endfunction

  // Record grants and the lengths of completed valid-high / valid-low runs.
  task automatic watch(input int ncyc);
    logic prev = 1'b0;
    int   run  = 0;
    grants.delete();
    gsrc.delete();
    hi_runs.delete();
    lo_runs.delete();
    for (int c = 0; c < ncyc; c++) begin
      step(1);
      if (ack != '0) begin
        check("ack_onehot", 32'($countones(ack)), 32'd1);
        grants.push_back(ack_idx(ack));
        gsrc.push_back(int'(disp_src));
      end
      if (disp_valid == prev) begin
        run++;
      end else begin
        if (run > 0) begin
          if (prev) hi_runs.push_back(run);
          else      lo_runs.push_back(run);
        end
        prev = disp_valid;
        run  = 1;
      end
    end
  endtask

  initial begin
    automatic int exp_g[5] = '{0, 1, 2, 3, 0};
    int n;
    int bad;
`ifdef SEVEN_SEG_SCHED_PRIO_EN
    automatic int exp_preempt_len = 1;
`else
    automatic int exp_preempt_len = 6;
`endif

    // Reset values
    rst_n = 1'b0;
    step(2);
    check("rst_valid", 32'(disp_valid), 32'd0);
    check("rst_byte", 32'(disp_byte), 32'd0);
    check("rst_src", 32'(disp_src), 32'd0);
    check("rst_ack", 32'(ack), 32'd0);
    rst_n = 1'b1;

    // Single request: one-cycle latency, one ack, live byte, drop blanks
    data = 32'h44A5_2211;
    req  = 4'b0100;
    step(1);
    check("t1_valid", 32'(disp_valid), 32'd1);
    check("t1_src", 32'(disp_src), 32'd2);
    check("t1_byte", 32'(disp_byte), 32'hA5);
    check("t1_ack", 32'(ack), 32'b0100);
    data[23:16] = 8'h5A;
    step(1);
    check("t1_ack_single", 32'(ack), 32'd0);
    check("t1_live_byte", 32'(disp_byte), 32'h5A);
    req = 4'b0000;
    step(1);
    check("t1_drop_valid", 32'(disp_valid), 32'd0);
    check("t1_drop_byte", 32'(disp_byte), 32'd0);

    // All sources requesting: 0,1,2,3,0 with 8-cycle shows and 2-cycle gaps
    do_reset();
    req = 4'b1111;
    watch(45);
    check("rr_grant_count", 32'(grants.size()), 32'd5);
    for (int i = 0; i < grants.size() && i < 5; i++) begin
      check($sformatf("rr_ack_%0d", i), 32'(grants[i]), 32'(exp_g[i]));
      check($sformatf("rr_src_%0d", i), 32'(gsrc[i]), 32'(exp_g[i]));
    end
    check("rr_show_runs", 32'(hi_runs.size()), 32'd4);
    foreach (hi_runs[i]) check($sformatf("rr_show_len_%0d", i), 32'(hi_runs[i]), 32'd8);
    check("rr_gap_runs", 32'(lo_runs.size()), 32'd4);
    foreach (lo_runs[i]) check($sformatf("rr_gap_len_%0d", i), 32'(lo_runs[i]), 32'd2);

    // Lone requester keeps the display without gaps or repeated acks
    do_reset();
    req = 4'b0010;
    watch(30);
    check("solo_grant_count", 32'(grants.size()), 32'd1);
    if (grants.size() > 0) check("solo_ack_src", 32'(grants[0]), 32'd1);
    check("solo_valid_drops", 32'(hi_runs.size()), 32'd0);
    check("solo_valid", 32'(disp_valid), 32'd1);
    check("solo_src", 32'(disp_src), 32'd1);
    // Asynchronous reset mid-show clears outputs without a clock edge
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_valid", 32'(disp_valid), 32'd0);
    check("async_rst_src", 32'(disp_src), 32'd0);
    check("async_rst_byte", 32'(disp_byte), 32'd0);
    step(1);
    rst_n = 1'b1;

    // Early drop with nobody waiting: blank, then idle, then rr resumes after source 2
    do_reset();
    data = 32'h44A5_2211;
    req  = 4'b0100;
    step(1);
    check("drop_grant_src", 32'(disp_src), 32'd2);
    step(3);
    req = 4'b0000;
    step(1);
    check("drop_blank_valid", 32'(disp_valid), 32'd0);
    check("drop_blank_byte", 32'(disp_byte), 32'd0);
    step(2);
    check("drop_idle_valid", 32'(disp_valid), 32'd0);
    check("drop_idle_ack", 32'(ack), 32'd0);
    step(1);
    check("drop_idle_stays", 32'(disp_valid), 32'd0);
    req = 4'b1001;
    step(1);
    check("idle_rr_src", 32'(disp_src), 32'd3);
    check("idle_rr_ack", 32'(ack), 32'b1000);

    // Early drop with others waiting: next requester after the blank gap
    do_reset();
    req = 4'b0100;
    step(4);
    req = 4'b0011;
    step(1);
    check("drop2_blank0", 32'(disp_valid), 32'd0);
    step(1);
    check("drop2_blank1", 32'(disp_valid), 32'd0);
    step(1);
    check("drop2_src", 32'(disp_src), 32'd0);
    check("drop2_ack", 32'(ack), 32'b0001);
    check("drop2_valid", 32'(disp_valid), 32'd1);

    // Hold freezes the dwell; switch after 8 unheld cycles in total
    do_reset();
    req = 4'b0011;
    step(1);
    check("hold_grant_src", 32'(disp_src), 32'd0);
    check("hold_grant_ack", 32'(ack), 32'b0001);
    step(2);
    hold = 1'b1;
    bad  = 0;
    for (int c = 0; c < 20; c++) begin
      step(1);
      if (!disp_valid || disp_src != 2'd0) bad++;
    end
    check("hold_no_switch", 32'(bad), 32'd0);
    hold = 1'b0;
    n = 0;
    do begin
      step(1);
      n++;
    end while (disp_valid && n < 50);
    check("hold_release_len", 32'(n), 32'd6);
    step(2);
    check("hold_next_src", 32'(disp_src), 32'd1);
    check("hold_next_ack", 32'(ack), 32'b0010);

    // Source 0 rising while source 3 shows
    do_reset();
    req = 4'b1000;
    step(1);
    check("prio_first_src", 32'(disp_src), 32'd3);
    step(2);
    req = 4'b1001;
    n = 0;
    do begin
      step(1);
      n++;
    end while (disp_valid && n < 50);
    check("prio_show_len", 32'(n), 32'(exp_preempt_len));
    step(2);
    check("prio_next_src", 32'(disp_src), 32'd0);
    check("prio_next_ack", 32'(ack), 32'b0001);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
